// File: rtl/dbg_pulse_stretch_mc_if.sv
// dbg_pulse_stretch_mc_if: trigger/config/status bundle.
// master drives start/len/retrig/clr; slave returns pulse/done/overrun.
interface dbg_pulse_stretch_mc_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8
);
  logic [NUM_CH-1:0]       start_i;
  logic [NUM_CH*CNT_W-1:0] len_i;
  logic [NUM_CH-1:0]       retrig_i;
  logic [NUM_CH-1:0]       clr_i;
  logic [NUM_CH-1:0]       pulse_o;
  logic [NUM_CH-1:0]       done_o;
  logic [NUM_CH-1:0]       overrun_o;

  modport master (
    output start_i, len_i, retrig_i, clr_i,
    input  pulse_o, done_o, overrun_o
  );

  modport slave (
    input  start_i, len_i, retrig_i, clr_i,
    output pulse_o, done_o, overrun_o
  );
endinterface

// File: rtl/dbg_pulse_stretch_mc.sv
// dbg_pulse_stretch_mc: multi-channel programmable pulse stretcher.
// clk_i, rst_i (async, active-high); bus: slave side of the bundle.
module dbg_pulse_stretch_mc #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_MODE   = 1
) (
  input logic                   clk_i,
  input logic                   rst_i,
  dbg_pulse_stretch_mc_if.slave bus
);
  logic [NUM_CH-1:0] start_s;
  logic [NUM_CH-1:0] start_q, start_d;
  logic [NUM_CH-1:0] trig_q, trig_d;
  logic [NUM_CH-1:0] pulse_q, pulse_d;
  logic [NUM_CH-1:0] done_q, done_d;
  logic [NUM_CH-1:0] ovr_q, ovr_d;
  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];
  logic [CNT_W-1:0]  len_c [NUM_CH];

  generate
    if (SYNC_STAGES > 0) begin : g_sync
      logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          for (int i = 0; i < SYNC_STAGES; i++)
            sync_q[i] <= '0;
        end else begin
          sync_q[0] <= bus.start_i;
          for (int i = 1; i < SYNC_STAGES; i++)
            sync_q[i] <= sync_q[i-1];
        end
      end
      assign start_s = sync_q[SYNC_STAGES-1];
    end else begin : g_nosync
      assign start_s = bus.start_i;
    end
  endgenerate

  // Trigger is registered once more so the counter loads at
  // edge SYNC_STAGES+1 after start_i is first sampled.
  always_comb begin
    start_d = start_s;
    if (EDGE_MODE != 0)
      trig_d = start_s & ~start_q;
    else
      trig_d = start_s;
  end

  always_comb begin
    for (int n = 0; n < NUM_CH; n++) begin
      len_c[n]   = bus.len_i[n*CNT_W +: CNT_W];
      cnt_d[n]   = cnt_q[n];
      done_d[n]  = 1'b0;
      ovr_d[n]   = ovr_q[n] & ~bus.clr_i[n];
      if (cnt_q[n] == '0) begin
        if (trig_q[n] && len_c[n] != '0)
          cnt_d[n] = len_c[n];
      end else if (trig_q[n] && bus.retrig_i[n] &&
                   len_c[n] != '0) begin
        cnt_d[n] = len_c[n];
      end else begin
        // Dropped trigger: set wins over a same-cycle clear.
        if (trig_q[n] && !bus.retrig_i[n])
          ovr_d[n] = 1'b1;
        cnt_d[n]  = cnt_q[n] - CNT_W'(1);
        done_d[n] = (cnt_q[n] == CNT_W'(1));
      end
      pulse_d[n] = (cnt_d[n] != '0);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      start_q <= '0;
      trig_q  <= '0;
      pulse_q <= '0;
      done_q  <= '0;
      ovr_q   <= '0;
      for (int n = 0; n < NUM_CH; n++)
        cnt_q[n] <= '0;
    end else begin
      start_q <= start_d;
      trig_q  <= trig_d;
      pulse_q <= pulse_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
      for (int n = 0; n < NUM_CH; n++)
        cnt_q[n] <= cnt_d[n];
    end
  end

  assign bus.pulse_o   = pulse_q;
  assign bus.done_o    = done_q;
  assign bus.overrun_o = ovr_q;
endmodule

// File: tb/tb_dbg_pulse_stretch_mc.sv
// tb_dbg_pulse_stretch_mc: scoreboard bench for the pulse stretcher.
// Reference model queues expected pulses; monitor pops on each fall.
module tb_dbg_pulse_stretch_mc;
  localparam int NC = 4;
  localparam int CW = 8;
  localparam int SS = 2;

  typedef struct {
    int rise;
    int width;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;

  dbg_pulse_stretch_mc_if #(.NUM_CH(NC), .CNT_W(CW)) bus ();
  dbg_pulse_stretch_mc_if #(.NUM_CH(NC), .CNT_W(CW)) alt ();

  dbg_pulse_stretch_mc #(
    .NUM_CH(NC), .CNT_W(CW),
    .SYNC_STAGES(SS), .EDGE_MODE(1)
  ) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus)
  );

  dbg_pulse_stretch_mc #(
    .NUM_CH(NC), .CNT_W(CW),
    .SYNC_STAGES(0), .EDGE_MODE(0)
  ) dut_alt (
    .clk_i(clk), .rst_i(rst), .bus(alt)
  );

  always #5 clk = ~clk;

  task automatic check(string nm, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Reference model: remaining-cycle count per channel.
  exp_t expq [NC][$];
  int   rem [NC];
  int   wid [NC];
  int   rise_m [NC];
  bit   ovr_m [NC];
  bit   hist [NC][SS+2];
  int   mcyc = 0;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      for (int c = 0; c < NC; c++) begin
        rem[c] = 0;
        wid[c] = 0;
        ovr_m[c] = 1'b0;
        for (int i = 0; i < SS+2; i++) hist[c][i] = 1'b0;
      end
    end else begin
      mcyc++;
      for (int c = 0; c < NC; c++) begin
        bit trig, was, drop;
        int len;
        trig = hist[c][SS] & ~hist[c][SS+1];
        len  = int'(bus.len_i[c*CW +: CW]);
        was  = (rem[c] != 0);
        drop = 1'b0;
        if (trig && len != 0 && (!was || bus.retrig_i[c])) begin
          if (!was) begin
            rise_m[c] = mcyc;
            wid[c] = 0;
          end
          rem[c] = len;
        end else if (was) begin
          drop = trig && !bus.retrig_i[c];
          rem[c] = rem[c] - 1;
        end
        if (drop) ovr_m[c] = 1'b1;
        else if (bus.clr_i[c]) ovr_m[c] = 1'b0;
        if (rem[c] != 0) wid[c]++;
        else if (was) expq[c].push_back('{rise_m[c], wid[c]});
        for (int i = SS+1; i > 0; i--) hist[c][i] = hist[c][i-1];
        hist[c][0] = bus.start_i[c];
      end
    end
  end

  // Monitor
  bit mon_prev [NC];
  int mon_w [NC];
  int mon_rise [NC];
  int last_w [NC];
  int last_rise [NC];
  int done_cnt [NC];
  int pulse_cnt [NC];

  initial forever begin
    @(negedge clk);
    if (rst) begin
      for (int c = 0; c < NC; c++) begin
        mon_prev[c] = 1'b0;
        mon_w[c] = 0;
      end
    end else begin
      for (int c = 0; c < NC; c++) begin
        bit p, d;
        exp_t e;
        p = bus.pulse_o[c];
        d = bus.done_o[c];
        if (p && !mon_prev[c]) begin
          mon_rise[c] = mcyc;
          mon_w[c] = 0;
          pulse_cnt[c]++;
        end
        if (p) mon_w[c]++;
        if (!p && mon_prev[c]) begin
          check($sformatf("done_at_fall ch%0d", c), int'(d), 1);
          if (expq[c].size() == 0) begin
            check($sformatf("unexpected_pulse ch%0d", c), 1, 0);
          end else begin
            e = expq[c].pop_front();
            check($sformatf("width ch%0d", c), mon_w[c], e.width);
            check($sformatf("rise ch%0d", c), mon_rise[c], e.rise);
          end
          last_w[c] = mon_w[c];
          last_rise[c] = mon_rise[c];
        end else begin
          check($sformatf("done_idle ch%0d", c), int'(d), 0);
        end
        if (d) done_cnt[c]++;
        check($sformatf("overrun ch%0d", c),
              int'(bus.overrun_o[c]), int'(ovr_m[c]));
        mon_prev[c] = p;
      end
    end
  end

  int alt_w = 0;
  int alt_done = 0;
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (alt.pulse_o[0]) alt_w++;
      if (alt.done_o[0]) alt_done++;
    end
  end

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_ch(int c, int len, bit rt);
    bus.len_i[c*CW +: CW] = CW'(len);
    bus.retrig_i[c] = rt;
  endtask

  task automatic pulse_start(int c);
    bus.start_i[c] = 1'b1;
    tick(1);
    bus.start_i[c] = 1'b0;
  endtask

  initial begin
    int d0, p0, t0;
    bus.start_i = '0;
    bus.len_i = '0;
    bus.retrig_i = '0;
    bus.clr_i = '0;
    alt.start_i = '0;
    alt.len_i = '0;
    alt.retrig_i = '0;
    alt.clr_i = '0;
    #20;
    check("rst_pulse", int'(bus.pulse_o), 0);
    check("rst_done", int'(bus.done_o), 0);
    check("rst_overrun", int'(bus.overrun_o), 0);
    #3 rst = 1'b0;
    tick(2);

    // T1: single 5-cycle pulse, latency 3 edges
    set_ch(0, 5, 1'b0);
    tick(1);
    d0 = done_cnt[0];
    t0 = mcyc + 1;
    pulse_start(0);
    tick(12);
    check("t1_width", last_w[0], 5);
    check("t1_latency", last_rise[0] - t0, 3);
    check("t1_done", done_cnt[0] - d0, 1);
    check("t1_overrun", int'(bus.overrun_o[0]), 0);

    // T2: retrigger 4 cycles into pulse
    set_ch(1, 10, 1'b1);
    tick(1);
    d0 = done_cnt[1];
    pulse_start(1);
    tick(3);
    pulse_start(1);
    tick(20);
    check("t2_width", last_w[1], 14);
    check("t2_done", done_cnt[1] - d0, 1);

    // T3: dropped trigger, sticky overrun, clear vs set
    set_ch(2, 10, 1'b0);
    tick(1);
    pulse_start(2);
    tick(3);
    pulse_start(2);
    tick(20);
    check("t3_width", last_w[2], 10);
    check("t3_overrun_set", int'(bus.overrun_o[2]), 1);
    bus.clr_i[2] = 1'b1;
    tick(1);
    bus.clr_i[2] = 1'b0;
    tick(1);
    check("t3_overrun_clr", int'(bus.overrun_o[2]), 0);
    pulse_start(2);
    tick(4);
    pulse_start(2);
    tick(2);
    bus.clr_i[2] = 1'b1;
    tick(1);
    bus.clr_i[2] = 1'b0;
    tick(1);
    check("t3_set_beats_clr", int'(bus.overrun_o[2]), 1);
    tick(10);

    // T4: len=0 ignored, len=255, level mode
    set_ch(3, 0, 1'b0);
    tick(1);
    p0 = pulse_cnt[3];
    d0 = done_cnt[3];
    pulse_start(3);
    tick(10);
    check("t4_len0_pulse", pulse_cnt[3] - p0, 0);
    check("t4_len0_done", done_cnt[3] - d0, 0);
    check("t4_len0_overrun", int'(bus.overrun_o[3]), 0);
    set_ch(3, 255, 1'b0);
    tick(1);
    pulse_start(3);
    tick(262);
    check("t4_len255", last_w[3], 255);
    alt.len_i[CW-1:0] = CW'(2);
    alt.retrig_i[0] = 1'b1;
    tick(1);
    alt.start_i[0] = 1'b1;
    tick(3);
    alt.start_i[0] = 1'b0;
    tick(8);
    check("t4_level_width", alt_w, 4);
    check("t4_level_done", alt_done, 1);

    // T5: async reset mid-pulse, start held across release
    set_ch(0, 20, 1'b0);
    tick(1);
    pulse_start(0);
    tick(8);
    #3 rst = 1'b1;
    bus.start_i[0] = 1'b1;
    #1;
    check("t5_rst_pulse", int'(bus.pulse_o), 0);
    check("t5_rst_done", int'(bus.done_o), 0);
    check("t5_rst_overrun", int'(bus.overrun_o), 0);
    d0 = done_cnt[0];
    p0 = pulse_cnt[0];
    tick(3);
    #2 rst = 1'b0;
    tick(40);
    bus.start_i[0] = 1'b0;
    tick(5);
    check("t5_one_pulse", pulse_cnt[0] - p0, 1);
    check("t5_one_done", done_cnt[0] - d0, 1);
    check("t5_width", last_w[0], 20);

    // T6: random multi-channel bursts with sub-cycle jitter
    for (int b = 0; b < 30; b++) begin
      for (int c = 0; c < NC; c++)
        set_ch(c,
               ($urandom_range(0, 7) == 0) ? 0
                 : int'($urandom_range(1, 40)),
               1'($urandom_range(0, 1)));
      for (int k = 0; k < 60; k++) begin
        @(negedge clk);
        #($urandom_range(0, 3));
        bus.start_i = NC'($urandom & $urandom);
        bus.clr_i = NC'($urandom & $urandom & $urandom);
      end
      @(negedge clk);
      bus.start_i = '0;
      bus.clr_i = '0;
      tick(8);
    end
    tick(60);
    for (int c = 0; c < NC; c++)
      check($sformatf("drain ch%0d", c), expq[c].size(), 0);
    check("final_pulse", int'(bus.pulse_o), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
